// File: rtl/gpio_debounce.sv
// gpio_debounce: synchronises, debounces and edge-flags 16 GPIO input pins,
// with a small memory-mapped register window on the peripheral bus.
module gpio_debounce #(
    parameter logic [15:0] BASE_ADDR = 16'h0438,
    parameter int unsigned DB_TICKS  = 4,
    parameter logic [15:0] PRESC_RST = 16'd99
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_data,
    output logic [15:0] o_data,
    input  logic [15:0] i_pins,
    output logic [15:0] o_gp,
    output logic        o_irq
);

    localparam int unsigned NPIN = 16;
    localparam int unsigned CW   = $clog2(DB_TICKS + 1);

    localparam logic [15:0] OFF_PIN   = 16'd0;
    localparam logic [15:0] OFF_PRESC = 16'd1;
    localparam logic [15:0] OFF_RISE  = 16'd2;
    localparam logic [15:0] OFF_FALL  = 16'd3;
    localparam logic [15:0] OFF_FLAGS = 16'd4;

    logic [15:0]   sync1;
    logic [15:0]   sync2;
    logic [15:0]   presc;
    logic [15:0]   presc_cnt;
    logic [15:0]   rise_en;
    logic [15:0]   fall_en;
    logic [15:0]   flags;
    logic [CW-1:0] cnt [NPIN];

    logic [15:0]   off;
    logic          tick;
    logic          presc_wr;
    logic [15:0]   gp_n;
    logic [CW-1:0] cnt_n [NPIN];
    logic [15:0]   flags_n;
    logic [15:0]   rd_c;

    // Address offset inside the window; addresses below the base wrap high and decode as unmapped.
    always_comb begin
        off      = i_addr - BASE_ADDR;
        tick     = (presc_cnt == presc);
        presc_wr = i_we && (off == OFF_PRESC);
    end

    // Per-pin debounce: DB_TICKS consecutive mismatching ticks accept the new level.
    always_comb begin
        gp_n = o_gp;
        for (int i = 0; i < NPIN; i++) begin
            cnt_n[i] = cnt[i];
            if (tick) begin
                if (sync2[i] == o_gp[i]) begin
                    cnt_n[i] = '0;
                end else if (cnt[i] + CW'(1) == CW'(DB_TICKS)) begin
                    gp_n[i]  = sync2[i];
                    cnt_n[i] = '0;
                end else begin
                    cnt_n[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Edge flags: new enabled edges set, W1C clears; a same-cycle set beats the clear.
    always_comb begin
        flags_n = flags;
        if (i_we && (off == OFF_FLAGS)) begin
            flags_n = flags & ~i_data;
        end
        flags_n = flags_n | (gp_n & ~o_gp & rise_en) | (~gp_n & o_gp & fall_en);
    end

    // Read mux; unmapped offsets read as zero.
    always_comb begin
        rd_c = '0;
        case (off)
            OFF_PIN:   rd_c = o_gp;
            OFF_PRESC: rd_c = presc;
            OFF_RISE:  rd_c = rise_en;
            OFF_FALL:  rd_c = fall_en;
            OFF_FLAGS: rd_c = flags;
            default:   rd_c = '0;
        endcase
    end

    // State registers: synchroniser, prescaler, debounce, bus registers and read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1     <= '0;
            sync2     <= '0;
            presc     <= PRESC_RST;
            presc_cnt <= '0;
            rise_en   <= '0;
            fall_en   <= '0;
            flags     <= '0;
            o_gp      <= '0;
            o_data    <= '0;
            for (int i = 0; i < NPIN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= i_pins;
            sync2 <= sync1;
            o_gp  <= gp_n;
            flags <= flags_n;
            for (int i = 0; i < NPIN; i++) begin
                cnt[i] <= cnt_n[i];
            end
            if (presc_wr || tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 16'd1;
            end
            if (i_we) begin
                case (off)
                    OFF_PRESC: presc   <= i_data;
                    OFF_RISE:  rise_en <= i_data;
                    OFF_FALL:  fall_en <= i_data;
                    default:   ;
                endcase
            end else begin
                o_data <= rd_c;
            end
        end
    end

    assign o_irq = |flags;

endmodule

// File: tb/tb_gpio_debounce.sv
// Testbench for gpio_debounce: directed scenarios plus random pin/bus traffic
// compared every cycle against a sample-history reference model.
module tb_gpio_debounce;

    localparam logic [15:0] BASE = 16'h0438;
    localparam int          DB   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] pins = '0;
    logic [15:0] rdata;
    logic [15:0] gp;
    logic        irq;

    always #5 clk = ~clk;

    gpio_debounce #(
        .BASE_ADDR (BASE),
        .DB_TICKS  (DB),
        .PRESC_RST (16'd99)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_we   (we),
        .i_addr (addr),
        .i_data (wdata),
        .o_data (rdata),
        .i_pins (pins),
        .o_gp   (gp),
        .o_irq  (irq)
    );

    // Reference model: a pin level is accepted once the last DB tick samples all disagree with it.
    logic [15:0]   m_s1, m_s2, m_presc, m_since, m_rise, m_fall, m_flags, m_gp, m_odata;
    logic [DB-1:0] m_hist [16];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        logic [15:0] o;
        o = a - BASE;
        case (o)
            16'd0:   return m_gp;
            16'd1:   return m_presc;
            16'd2:   return m_rise;
            16'd3:   return m_fall;
            16'd4:   return m_flags;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic w, input logic [15:0] a,
                              input logic [15:0] d, input logic [15:0] p);
        logic        tick;
        logic [15:0] nxt, clr, o;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_presc = 16'd99; m_since = '0;
            m_rise = '0; m_fall = '0; m_flags = '0; m_gp = '0; m_odata = '0;
            for (int i = 0; i < 16; i++) m_hist[i] = '0;
        end else begin
            o    = a - BASE;
            tick = (m_since == m_presc);
            nxt  = m_gp;
            if (tick) begin
                for (int i = 0; i < 16; i++) begin
                    m_hist[i] = {m_hist[i][DB-2:0], m_s2[i]};
                    if (m_hist[i] == {DB{~m_gp[i]}}) nxt[i] = ~m_gp[i];
                end
            end
            if (!w) m_odata = m_read(a);
            clr     = (w && o == 16'd4) ? d : 16'h0000;
            m_flags = (m_flags & ~clr) | (nxt & ~m_gp & m_rise) | (~nxt & m_gp & m_fall);
            if (w && o == 16'd1) m_presc = d;
            if (w && o == 16'd2) m_rise  = d;
            if (w && o == 16'd3) m_fall  = d;
            m_since = ((w && o == 16'd1) || tick) ? 16'd0 : m_since + 16'd1;
            m_gp = nxt;
            m_s2 = m_s1;
            m_s1 = p;
        end
    endtask

    // One clock: inputs are stable across the edge, outputs checked 1 time unit after it.
    task automatic cyc();
        logic        r, w;
        logic [15:0] a, d, p;
        r = rst; w = we; a = addr; d = wdata; p = pins;
        @(posedge clk);
        #1;
        model_step(r, w, a, d, p);
        chk("gp", gp, m_gp);
        chk("irq", {15'b0, irq}, {15'b0, |m_flags});
        chk("odata", rdata, m_odata);
    endtask

    task automatic wr(input logic [15:0] off, input logic [15:0] d);
        we = 1'b1; addr = BASE + off; wdata = d;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] off);
        we = 1'b0; addr = BASE + off;
        cyc();
    endtask

    initial begin
        int n;
        logic [15:0] off;

        // Reset and reset values
        repeat (2) cyc();
        chk("rst_gp", gp, 16'h0000);
        chk("rst_irq", {15'b0, irq}, 16'h0000);
        rst = 1'b0;
        rd(16'd1);
        chk("rst_presc", rdata, 16'd99);
        rd(16'd0);
        chk("rst_pin", rdata, 16'h0000);

        // Basic debounce latency with PRESC=0
        wr(16'd1, 16'd0);
        wr(16'd2, 16'h0001);
        pins = 16'h0001;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("lat_gp", gp, (k == 6) ? 16'h0001 : 16'h0000);
        end
        chk("lat_irq", {15'b0, irq}, 16'h0001);

        // Short glitch is rejected
        pins[3] = 1'b1;
        repeat (3) cyc();
        pins[3] = 1'b0;
        repeat (8) cyc();
        chk("glitch_gp", gp, 16'h0001);
        rd(16'd4);
        chk("glitch_flags", rdata, 16'h0001);

        // W1C of individual flags
        wr(16'd2, 16'h0005);
        pins[2] = 1'b1;
        repeat (7) cyc();
        rd(16'd4);
        chk("flags5", rdata, 16'h0005);
        wr(16'd4, 16'h0001);
        rd(16'd4);
        chk("w1c_a", rdata, 16'h0004);
        chk("w1c_a_irq", {15'b0, irq}, 16'h0001);
        wr(16'd4, 16'h0004);
        rd(16'd4);
        chk("w1c_b", rdata, 16'h0000);
        chk("w1c_b_irq", {15'b0, irq}, 16'h0000);

        // Prescaler latency and set/clear collision on FLAGS[15]
        wr(16'd3, 16'h8000);
        pins[15] = 1'b1;
        repeat (7) cyc();
        chk("p15_high", gp & 16'h8000, 16'h8000);
        wr(16'd1, 16'd9);
        repeat ($urandom_range(0, 9)) cyc();
        pins[15] = 1'b0;
        we = 1'b1; addr = BASE + 16'd4; wdata = 16'h8000;
        n = 0;
        while (gp[15] === 1'b1 && n < 60) begin
            cyc();
            n++;
        end
        we = 1'b0;
        chk("presc_lat_in_range", {15'b0, (n >= 32 && n <= 42)}, 16'h0001);
        rd(16'd4);
        chk("collision_flag", rdata, 16'h8000);
        chk("collision_irq", {15'b0, irq}, 16'h0001);

        // Random pin and bus traffic against the model
        for (int c = 0; c < 2000; c++) begin
            pins = pins ^ (16'($urandom) & 16'($urandom) & 16'($urandom) & 16'($urandom) & 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                we = 1'b1;
                off = 16'($urandom_range(0, 6));
                addr = BASE + off;
                wdata = (off == 16'd1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            end else begin
                we = 1'b0;
                addr = ($urandom_range(0, 9) == 0) ? BASE - 16'd1 : BASE + 16'($urandom_range(0, 7));
            end
            cyc();
        end
        we = 1'b0;

        // Reset in the middle of a debounce discards the count
        wr(16'd1, 16'd0);
        pins = 16'h0000;
        repeat (10) cyc();
        wr(16'd4, 16'hffff);
        chk("pre_rst_gp", gp, 16'h0000);
        pins = 16'h0001;
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        chk("mid_rst_gp", gp, 16'h0000);
        chk("mid_rst_irq", {15'b0, irq}, 16'h0000);
        rst = 1'b0;
        wr(16'd1, 16'd0);
        for (int k = 2; k <= 6; k++) begin
            cyc();
            chk("post_rst_gp", gp, (k == 6) ? 16'h0001 : 16'h0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
